stack_sequencer: RTL
====================

Name: stack_sequencer

Overview:
- Stack-side master for the RNBIP-2 data memory: the initiator that drives the memory's write strobe (WR), address-select (S20) and data-select (S50) controls.
- Sequences PUSH, POP, CALL and RET as multi-cycle operations.
- Owns the stack pointer and returns popped data to the register file (POP) or the PC (RET).
- Sits between instruction decode and the single-port 256x8 data memory, whose read is combinational.

Parameters:
- SP_RESET, 8'hFF, stack pointer value after reset; this value means the stack is empty.
- STACK_LIMIT, 8'hC0, lowest address the stack may occupy; must be >=1 and <= SP_RESET.
- Depth is SP_RESET-STACK_LIMIT+1, which is 64 entries by default.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- op_valid  in  1  operation request.
- op_code  in  2  00=PUSH, 01=POP, 10=CALL, 11=RET.
- op_ready  out  1  block idle and able to accept an op.
- rn_in  in  8  register value to push (PUSH).
- npc_in  in  8  return address to push (CALL).
- target_in  in  8  call destination (CALL).
- mem_dout  in  8  data memory read data, combinational on address.
- mem_wr  out  1  data memory write strobe (WR).
- s20  out  1  memory address select: 1=SP, 0=R0.
- s50  out  1  memory write-data select: 1=RN, 0=NPC.
- sp_out  out  8  current stack pointer, drives memory SP input.
- rn_load  out  1  register-file write strobe for popped data.
- rn_data  out  8  popped data for the register file.
- pc_load  out  1  PC load strobe.
- pc_data  out  8  new PC value.
- ovf  out  1  sticky: push or call attempted while the stack is full.
- unf  out  1  sticky: pop or ret attempted while the stack is empty.

Behaviour:
- Reset values:
  - state=IDLE, SP=SP_RESET, latched operands=0, ovf=unf=0.
  - All strobes 0; rn_data=pc_data=0.
  - op_ready=0 while rst is high.
- SP convention: SP points to the next free slot.
  - Empty: SP==SP_RESET.
  - Full: SP==STACK_LIMIT-1.
  - Push writes mem[SP], then SP-1. Pop does SP+1, then reads mem[SP].
  - No wrap-around ever occurs; the full and empty checks prevent it.
- States: IDLE, PUSH_W, POP_INC, POP_RD.
- Outputs are Moore-decoded from state and latched operands. Outside the states listed below, mem_wr=s20=s50=rn_load=pc_load=0 and rn_data=pc_data=0.
- IDLE:
  - op_ready=1. Accept on op_valid&op_ready; latch op_code, rn_in, npc_in and target_in.
  - PUSH/CALL when full: set ovf, stay IDLE, no memory write.
  - POP/RET when empty: set unf, stay IDLE, no load.
  - Otherwise PUSH/CALL go to PUSH_W, and POP/RET go to POP_INC.
- PUSH_W (1 cycle):
  - mem_wr=1, s20=1.
  - s50=1 for PUSH (RN data), 0 for CALL (NPC data).
  - CALL only: pc_load=1, pc_data=latched target.
  - At the cycle end the memory captures at the old SP and SP<=SP-1. Next state IDLE.
- POP_INC (1 cycle): SP<=SP+1; no strobes. Next state POP_RD.
- POP_RD (1 cycle):
  - s20=1.
  - POP: rn_load=1, rn_data=mem_dout.
  - RET: pc_load=1, pc_data=mem_dout.
  - SP unchanged. Next state IDLE.
- Latency from the accept edge:
  - PUSH/CALL: write strobe in the next cycle; op_ready back 2 cycles after accept.
  - POP/RET: load strobe 2 cycles after accept; op_ready back 3 cycles after accept.
  - Error ops: op_ready stays 1, so the next op can be accepted the following cycle.
- sp_out always reflects the SP register.
- s20=0 whenever the block is not accessing the stack, so R0 addressing owns the memory at all other times.
- ovf and unf are sticky. Only reset clears them. They do not block later valid ops.
- Reset mid-operation: the state machine aborts to IDLE and SP returns to SP_RESET. A write or load strobe that was in progress is not asserted in the cycle after the reset edge.
- op_valid is ignored while op_ready=0; no queuing.

Test Plan:
- Reset -> sp_out=FF, op_ready=1, ovf=unf=0, mem_wr=s20=rn_load=pc_load=0.
- PUSH with rn_in=5A -> next cycle: mem_wr=1, s20=1, s50=1, sp_out=FF. Following cycle: sp_out=FE, op_ready=1. mem[FF]=5A.
- POP after the above -> POP_INC: sp_out becomes FF. POP_RD: s20=1, rn_load=1, rn_data=5A. Back to IDLE with sp_out=FF.
- CALL with npc_in=11, target_in=40 -> PUSH_W: mem_wr=1, s50=0, pc_load=1, pc_data=40, mem[FF]=11. Then RET -> POP_RD: pc_load=1, pc_data=11, sp_out=FF.
- Overflow and underflow:
  - POP from empty -> unf=1, no rn_load, sp_out=FF.
  - 64 PUSHes -> sp_out=BF.
  - 65th PUSH -> ovf=1, no mem_wr, sp_out stays BF.
  - A following POP succeeds and returns the last pushed value.
- Reset asserted during POP_INC of a POP -> next cycle: state IDLE, sp_out=FF, rn_load never asserted, op_ready=1 after rst deasserts.

Source files
------------

// File: rtl/stack_sequencer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | stack_sequencer: PUSH/POP/CALL/RET sequencer for the RNBIP-2 data memory  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module stack_sequencer #(
  parameter logic [7:0] SP_RESET    = 8'hFF,
  parameter logic [7:0] STACK_LIMIT = 8'hC0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  input  logic [1:0] op_code,
  output logic       op_ready,
  input  logic [7:0] rn_in,
  input  logic [7:0] npc_in,
  input  logic [7:0] target_in,
  input  logic [7:0] mem_dout,
  output logic       mem_wr,
  output logic       s20,
  output logic       s50,
  output logic [7:0] sp_out,
  output logic       rn_load,
  output logic [7:0] rn_data,
  output logic       pc_load,
  output logic [7:0] pc_data,
  output logic       ovf,
  output logic       unf
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PUSH_W  = 2'd1;
  localparam logic [1:0] S_POP_INC = 2'd2;
  localparam logic [1:0] S_POP_RD  = 2'd3;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  localparam logic [7:0] SP_FULL = STACK_LIMIT - 8'd1;

  logic [1:0] state_q, state_d;
  logic [7:0] sp_q, sp_d;
  logic [1:0] op_q, op_d;
  logic [7:0] rn_q, rn_d;
  logic [7:0] npc_q, npc_d;
  logic [7:0] tgt_q, tgt_d;
  logic       ovf_q, ovf_d;
  logic       unf_q, unf_d;

  logic w_full;
  logic w_empty;

  assign w_full   = (sp_q == SP_FULL);
  assign w_empty  = (sp_q == SP_RESET);
  assign op_ready = (state_q == S_IDLE) && !rst;

  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    op_d    = op_q;
    rn_d    = rn_q;
    npc_d   = npc_q;
    tgt_d   = tgt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid && op_ready) begin
          op_d  = op_code;
          rn_d  = rn_in;
          npc_d = npc_in;
          tgt_d = target_in;
          // op_code[0]==0 selects the writing ops (PUSH/CALL)
          if (!op_code[0]) begin
            if (w_full) ovf_d = 1'b1;
            else        state_d = S_PUSH_W;
          end else begin
            if (w_empty) unf_d = 1'b1;
            else         state_d = S_POP_INC;
          end
        end
      end
      S_PUSH_W: begin
        sp_d    = sp_q - 8'd1;
        state_d = S_IDLE;
      end
      S_POP_INC: begin
        sp_d    = sp_q + 8'd1;
        state_d = S_POP_RD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sp_q    <= SP_RESET;
      op_q    <= 2'b00;
      rn_q    <= 8'h00;
      npc_q   <= 8'h00;
      tgt_q   <= 8'h00;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      op_q    <= op_d;
      rn_q    <= rn_d;
      npc_q   <= npc_d;
      tgt_q   <= tgt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Write data reaches memory through the s50 mux, so the latched copies have no local reader.
  logic unused_operands;
  assign unused_operands = ^{rn_q, npc_q};

  always_comb begin
    mem_wr  = 1'b0;
    s20     = 1'b0;
    s50     = 1'b0;
    rn_load = 1'b0;
    rn_data = 8'h00;
    pc_load = 1'b0;
    pc_data = 8'h00;
    case (state_q)
      S_PUSH_W: begin
        mem_wr = 1'b1;
        s20    = 1'b1;
        s50    = (op_q == OP_PUSH);
        if (op_q == OP_CALL) begin
          pc_load = 1'b1;
          pc_data = tgt_q;
        end
      end
      S_POP_RD: begin
        s20 = 1'b1;
        if (op_q == OP_POP) begin
          rn_load = 1'b1;
          rn_data = mem_dout;
        end
        if (op_q == OP_RET) begin
          pc_load = 1'b1;
          pc_data = mem_dout;
        end
      end
      default: ;
    endcase
  end

  assign sp_out = sp_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;

endmodule
`default_nettype wire
